// File: rtl/addsub_serial_ctrl.sv
// Nibble-serial WIDTH-bit add/subtract sequencer driving one 4-bit slice, LSB nibble first.
// Optional signed-overflow output enabled by defining OVF_DETECT_EN.
module addsub_serial_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
`ifdef OVF_DETECT_EN
  ,
  output logic             overflow
`endif
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sub_q, sub_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       b_x;
  logic [4:0]       slice;
`ifdef OVF_DETECT_EN
  logic             ovf_q, ovf_d;
  logic [3:0]       low3;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef OVF_DETECT_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      work_q   <= work_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      sub_q    <= sub_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef OVF_DETECT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  // Next-state, slice operation and output register inputs
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    work_d   = work_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    sub_d    = sub_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    b_x      = b_q[3:0] ^ {4{sub_q}};
    slice    = 5'(a_q[3:0]) + 5'(b_x) + 5'(carry_q);
`ifdef OVF_DETECT_EN
    ovf_d    = ovf_q;
    low3     = 4'(a_q[2:0]) + 4'(b_x[2:0]) + 4'(carry_q);
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          a_d     = a;
          b_d     = b;
          sub_d   = sub;
          carry_d = sub;
          cnt_d   = '0;
          work_d  = '0;
        end
      end
      S_RUN: begin
        // Operands shift down so the active nibble is always at [3:0]
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        work_d  = {slice[3:0], work_q[WIDTH-1:4]};
        carry_d = slice[4];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d  = S_DONE;
          result_d = {slice[3:0], work_q[WIDTH-1:4]};
          cout_d   = slice[4];
`ifdef OVF_DETECT_EN
          ovf_d    = low3[3] ^ slice[4];
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign carry_out = cout_q;
`ifdef OVF_DETECT_EN
  assign overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// Scoreboard bench for addsub_serial_ctrl (WIDTH=16); overflow checks compiled in with OVF_DETECT_EN.
module tb_addsub_serial_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  typedef struct {
    logic [WIDTH-1:0] r;
    logic             c;
    logic             o;
    string            name;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             sub = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
`ifdef OVF_DETECT_EN
  logic             overflow;
`endif

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  exp_t sb[$];
  logic [WIDTH-1:0] last_r = '0;

  addsub_serial_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef OVF_DETECT_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops and compares one expected transaction
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, 32'(result), 32'(e.r));
        chk({e.name, "_carry"}, 32'(carry_out), 32'(e.c));
`ifdef OVF_DETECT_EN
        chk({e.name, "_ovf"}, 32'(overflow), 32'(e.o));
`endif
      end
    end
  end

  // Issues one op from a negedge in IDLE, then follows it to the return of IDLE
  task automatic run_op(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sv, input logic [WIDTH-1:0] er, input logic ec, input logic eo,
                        input bit measure);
    exp_t e;
    int   n = 0;
    int   g = 0;
    int   done_pos = 0;
    int   done_hi = 0;
    while (busy && g < 50) begin @(negedge clk); g++; end
    if (busy) chk({name, "_idle_timeout"}, 32'(busy), 32'(0));
    e.r = er; e.c = ec; e.o = eo; e.name = name;
    sb.push_back(e);
    a = av; b = bv; sub = sv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = ~av; b = av ^ 16'h5A5A; sub = ~sv;
    while (busy && n < 20) begin
      n++;
      if (done) begin done_hi++; done_pos = n; end
      if (n == 2) chk({name, "_result_held"}, 32'(result), 32'(last_r));
      @(negedge clk);
    end
    if (measure) begin
      chk({name, "_busy_cycles"}, 32'(n), 32'(NIB + 1));
      chk({name, "_done_width"}, 32'(done_hi), 32'(1));
      chk({name, "_done_cycle"}, 32'(done_pos), 32'(NIB + 1));
    end
    last_r = er;
  endtask

  initial begin
    int d0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_carry", 32'(carry_out), 32'(0));
`ifdef OVF_DETECT_EN
    chk("rst_ovf", 32'(overflow), 32'(0));
`endif
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_1234_0fcd", 16'h1234, 16'h0FCD, 1'b0, 16'h2201, 1'b0, 1'b0, 1'b1);
    run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_op("add_0000_0000", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_5_7",       16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_op("sub_7_5",       16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);
    run_op("sub_abcd_abcd", 16'hABCD, 16'hABCD, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);

    // Start re-pulsed during RUN must be ignored
    begin
      exp_t e;
      int g = 0;
      d0 = done_cnt;
      e.r = 16'h0002; e.c = 1'b0; e.o = 1'b0; e.name = "busy_start";
      sb.push_back(e);
      a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 16'h00FF; b = 16'h00FF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (busy && g < 20) begin @(negedge clk); g++; end
      repeat (3) @(negedge clk);
      chk("busy_start_done_count", 32'(done_cnt - d0), 32'(1));
      chk("busy_start_no_second_op", 32'(busy), 32'(0));
      last_r = 16'h0002;
    end

    // Back-to-back: second op launched the cycle after done
    run_op("b2b_first",  16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b0);
    run_op("b2b_second", 16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset during the second RUN cycle
    d0 = done_cnt;
    a = 16'h4321; b = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_done", 32'(done), 32'(0));
    chk("mid_rst_result", 32'(result), 32'(0));
    chk("mid_rst_carry", 32'(carry_out), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (NIB + 3) @(negedge clk);
    chk("mid_rst_no_done", 32'(done_cnt - d0), 32'(0));
    last_r = '0;
    run_op("post_rst_1111_2222", 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1);

    run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    run_op("add_0001_0001", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
